fifo_stream_framer: RTL and testbench

Downstream drain stage for the team's synchronous FIFO. Pops words from the FIFO read port, honouring its registered-read latency, and emits them on a valid/ready stream framed into packets of FRAME_LEN beats with `o_last`. A one-word lookahead buffer lets a partial frame be closed with `o_last` when the FIFO runs dry for TIMEOUT cycles.

---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_out_reg.sv | 39 +++
 rtl/fifo_stream_framer.sv | 123 ++++++++++++
 tb/tb_fifo_stream_framer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the FIFO stream framer.
package stream_pkg;

  typedef enum logic [0:0] {
    O_EMPTY = 1'b0,
    O_PEND  = 1'b1
  } out_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register carrying a data word and its last flag.
module stream_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_valid
);

  logic [WIDTH-1:0] data_r;
  logic             last_r;
  logic             valid_r;

  // Load a new beat, or drop valid once the held beat has been accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_r  <= '0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (i_load) begin
      data_r  <= i_data;
      last_r  <= i_last;
      valid_r <= 1'b1;
    end else if (valid_r && i_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign o_data  = data_r;
  assign o_last  = last_r;
  assign o_valid = valid_r;

endmodule

// File: rtl/fifo_stream_framer.sv
// Drains a registered-read FIFO into a valid/ready stream framed in FRAME_LEN beats,
// closing a partial frame when the FIFO stays dry for TIMEOUT cycles.
module fifo_stream_framer
  import stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_rd_incr,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic                   o_short_frame
);

  localparam int BEAT_W = $clog2(FRAME_LEN + 1);
  localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT);

  out_state_t               state_r;
  out_state_t               state_nxt_s;
  logic [WIDTH-1:0]         pend_data_r;
  logic                     empty_d_r;
  logic                     pop_d_r;
  logic [TMR_W-1:0]         timer_r;
  logic [BEAT_W-1:0]        beat_cnt_r;
  logic                     short_r;
  logic [FRAME_CNT_W-1:0]   frame_cnt_r;

  logic fetch_ok_s;
  logic pend_valid_s;
  logic out_free_s;
  logic beat_last_s;
  logic timeout_s;
  logic capture_s;
  logic transfer_s;
  logic xfer_last_s;
  logic xfer_short_s;

  // Fetch gating, pending-slot transfer decision and output FSM next state
  always_comb begin
    fetch_ok_s   = !i_rst && !i_fifo_empty && !empty_d_r && !pop_d_r;
    pend_valid_s = (state_r == O_PEND);
    out_free_s   = !o_valid || i_ready;
    beat_last_s  = (beat_cnt_r == BEAT_LAST);
    timeout_s    = (TIMEOUT != 0) && (timer_r == TMR_MAX);
    // A capture into a full slot always pushes the old word out in the same cycle
    capture_s    = fetch_ok_s && (!pend_valid_s || out_free_s);
    transfer_s   = pend_valid_s && out_free_s && (fetch_ok_s || beat_last_s || timeout_s);
    if (fetch_ok_s) begin
      xfer_last_s  = beat_last_s;
      xfer_short_s = 1'b0;
    end else begin
      xfer_last_s  = 1'b1;
      xfer_short_s = !beat_last_s;
    end
    state_nxt_s = state_r;
    case (state_r)
      O_EMPTY: begin
        if (capture_s) state_nxt_s = O_PEND;
        else           state_nxt_s = O_EMPTY;
      end
      O_PEND: begin
        if (transfer_s && !capture_s) state_nxt_s = O_EMPTY;
        else                          state_nxt_s = O_PEND;
      end
      default: state_nxt_s = O_EMPTY;
    endcase
  end

  // Pending slot, fetch history, idle timer, beat and frame counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= O_EMPTY;
      pend_data_r <= '0;
      empty_d_r   <= 1'b1;
      pop_d_r     <= 1'b0;
      timer_r     <= '0;
      beat_cnt_r  <= '0;
      short_r     <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      empty_d_r <= i_fifo_empty;
      pop_d_r   <= capture_s;
      if (capture_s) pend_data_r <= i_fifo_data;
      if (capture_s || transfer_s)
        timer_r <= '0;
      else if (pend_valid_s && (timer_r != TMR_MAX))
        timer_r <= timer_r + TMR_W'(1);
      if (transfer_s) begin
        beat_cnt_r <= xfer_last_s ? '0 : beat_cnt_r + BEAT_W'(1);
        short_r    <= xfer_short_s;
      end
      if (o_valid && i_ready && o_last) frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
    end
  end

  stream_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (transfer_s),
    .i_data  (pend_data_r),
    .i_last  (xfer_last_s),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_valid (o_valid)
  );

  assign o_fifo_rd_incr = capture_s;
  assign o_short_frame  = o_valid && i_ready && short_r;
  assign o_frame_count  = frame_cnt_r;

endmodule

// File: tb/tb_fifo_stream_framer.sv
// Directed bench for fifo_stream_framer: a registered-read FIFO model feeds the DUT,
// a negedge monitor records pops and accepted beats, and the main sequence checks them.
module tb_fifo_stream_framer;

  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 4;
  localparam int TIMEOUT   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic [WIDTH-1:0]  fifo_data_r;
  logic              fifo_empty;
  logic              rd_incr;
  logic [WIDTH-1:0]  o_data;
  logic              o_valid;
  logic              o_last;
  logic [15:0]       frame_count;
  logic              short_frame;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_stream_framer #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fifo_data    (fifo_data_r),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_rd_incr (rd_incr),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_last         (o_last),
    .i_ready        (ready),
    .o_frame_count  (frame_count),
    .o_short_frame  (short_frame)
  );

  // FIFO model: head word registered one cycle behind the read pointer
  logic [WIDTH-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    fifo_data_r <= mem[rd_ptr[5:0]];
    if (rd_incr) rd_ptr <= rd_ptr + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  logic [16:0] acc_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];
  int          pops = 0;
  int          spacing_err = 0;
  int          stable_err = 0;
  int          short_cnt = 0;

  initial begin
    int last_pop_cyc;
    logic prev_stall;
    logic [16:0] prev_out;
    last_pop_cyc = -10;
    prev_stall = 1'b0;
    prev_out = 17'h0;
    forever begin
      @(negedge clk);
      if (rd_incr) begin
        if (cyc - last_pop_cyc < 2) spacing_err++;
        last_pop_cyc = cyc;
        pops++;
        pop_cyc_q.push_back(cyc);
      end
      if (o_valid && ready) begin
        acc_q.push_back({o_last, o_data});
        acc_cyc_q.push_back(cyc);
      end
      if (short_frame) short_cnt++;
      if (prev_stall && o_valid && ({o_last, o_data} !== prev_out)) stable_err++;
      prev_stall = o_valid && !ready;
      prev_out = {o_last, o_data};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_acc(input int n, input int budget, input logic toggle);
    int k = 0;
    while ((acc_q.size() < n) && (k < budget)) begin
      if (toggle) ready = ~ready;
      step();
      k++;
    end
  endtask

  task automatic check_beats(input string tag, input logic [WIDTH-1:0] base, input int n,
                             input logic [15:0] last_mask);
    logic [WIDTH-1:0] exp_data;
    logic             exp_last;
    check({tag, "_count"}, acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      exp_data = base + WIDTH'(i);
      exp_last = last_mask[i];
      check($sformatf("%s_beat%0d", tag, i), {15'h0, acc_q[i]}, {15'h0, exp_last, exp_data});
    end
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    for (int i = 1; i <= 8; i++) push(16'(i));

    // Reset defaults with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ctl", {28'h0, o_valid, o_last, rd_incr, short_frame}, 32'h0);
      check("rst_data_cnt", {o_data, frame_count}, 32'h0);
    end
    check("rst_no_pop", pops, 0);

    // Two full frames
    rst   = 1'b0;
    ready = 1'b1;
    wait_acc(8, 80, 1'b0);
    check_beats("full", 16'h0001, 8, 16'h0088);
    step();
    check("full_frames", frame_count, 2);
    check("full_pops", pops, 8);
    check("full_spacing", spacing_err, 0);
    check("full_short", short_cnt, 0);

    // Partial frame closed by the idle timer
    acc_q.delete();
    acc_cyc_q.delete();
    base = pop_cyc_q.size();
    push(16'h00A0);
    push(16'h00A1);
    push(16'h00A2);
    wait_acc(3, 60, 1'b0);
    check_beats("flush", 16'h00A0, 3, 16'h0004);
    if ((pop_cyc_q.size() > base + 2) && (acc_cyc_q.size() > 2))
      check("flush_latency", acc_cyc_q[2] - (pop_cyc_q[base + 2] + 1), TIMEOUT + 1);
    else
      check("flush_latency_seen", 0, 1);
    step();
    check("flush_short", short_cnt, 1);
    check("flush_frames", frame_count, 3);
    check("flush_idle", o_valid, 1'b0);

    // Backpressure: stall 20 cycles with six words queued
    ready = 1'b0;
    acc_q.delete();
    base = pops;
    for (int i = 1; i <= 6; i++) push(16'h0D00 + 16'(i));
    repeat (20) step();
    check("bp_pops_le2", (pops - base) <= 2, 1);
    check("bp_hold", {15'h0, o_valid, o_data}, {15'h0, 1'b1, 16'h0D01});
    check("bp_stable", stable_err, 0);
    check("bp_none_acc", acc_q.size(), 0);
    ready = 1'b1;
    wait_acc(6, 80, 1'b0);
    check_beats("bp", 16'h0D01, 6, 16'h0028);
    step();
    check("bp_frames", frame_count, 5);
    check("bp_short", short_cnt, 2);

    // Reset after two beats of a frame, then a fresh frame
    acc_q.delete();
    push(16'h0E01);
    push(16'h0E02);
    push(16'h0E03);
    wait_acc(2, 40, 1'b0);
    check("mid_two_acc", acc_q.size(), 2);
    rst = 1'b1;
    step();
    check("mid_rst_ctl", {29'h0, o_valid, o_last, short_frame}, 32'h0);
    check("mid_rst_data_cnt", {o_data, frame_count}, 32'h0);
    rst = 1'b0;
    acc_q.delete();
    repeat (12) step();
    check("mid_discard", acc_q.size(), 0);
    for (int i = 1; i <= 4; i++) push(16'h0F00 + 16'(i));
    wait_acc(4, 60, 1'b0);
    check_beats("mid", 16'h0F01, 4, 16'h0008);
    step();
    check("mid_frames", frame_count, 1);

    // Ready toggling every cycle across twelve words
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc_q.delete();
    base = short_cnt;
    for (int i = 1; i <= 12; i++) push(16'h0C00 + 16'(i));
    ready = 1'b1;
    wait_acc(12, 200, 1'b1);
    ready = 1'b1;
    repeat (3) step();
    check_beats("tog", 16'h0C01, 12, 16'h0888);
    check("tog_frames", frame_count, 3);
    check("tog_short", short_cnt - base, 0);
    check("tog_spacing", spacing_err, 0);
    check("tog_stable", stable_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
